// File: rtl/fft_bin_streamer_if.sv
// Handshake bundle between an FFT core's parallel result bus and the bin streamer.
// slave is the streamer's view; master is the producer/consumer side.
interface fft_bin_streamer_if #(
    parameter int unsigned N_POINTS = 16,
    parameter int unsigned WIDTH    = 16
);
    localparam int unsigned IDXW = $clog2(N_POINTS);

    logic                      in_valid;
    logic                      in_ready;
    logic [N_POINTS*WIDTH-1:0] in_re;
    logic [N_POINTS*WIDTH-1:0] in_im;
    logic                      in_fmt;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_re;
    logic [WIDTH-1:0]          out_im;
    logic [IDXW-1:0]           out_index;
    logic                      out_last;
    logic                      out_sat;

    modport master (
        output in_valid, in_re, in_im, in_fmt, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last, out_sat
    );

    modport slave (
        input  in_valid, in_re, in_im, in_fmt, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last, out_sat
    );
endinterface

// File: rtl/fft_bin_streamer.sv
// Captures one N-point complex FFT frame from a parallel bus and streams the
// bins out in natural order, one per beat, with optional sign-magnitude output.
module fft_bin_streamer #(
    parameter int unsigned N_POINTS = 16,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned REV_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    fft_bin_streamer_if.slave bus
);
    localparam int unsigned     IDXW   = $clog2(N_POINTS);
    localparam logic [IDXW-1:0] LAST_K = IDXW'(N_POINTS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_re [N_POINTS];
    logic [WIDTH-1:0] r_im [N_POINTS];
    logic             r_fmt;
    logic [IDXW-1:0]  r_k;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [IDXW-1:0]  w_slot;
    logic [WIDTH:0]   w_fmt_re;
    logic [WIDTH:0]   w_fmt_im;

    // Slot holding natural bin k, given how the FFT core orders its outputs.
    function automatic logic [IDXW-1:0] slot_of(input logic [IDXW-1:0] k);
        logic [IDXW-1:0] src;
        logic [IDXW-1:0] dst;
        src = k;
        dst = '0;
        if (REV_MODE == 1) begin
            for (int unsigned b = 0; b < IDXW; b++) begin
                dst = (dst << 1) | IDXW'(src & IDXW'(1));
                src = src >> 1;
            end
        end else if (REV_MODE == 2) begin
            for (int unsigned d = 0; d < IDXW / 2; d++) begin
                dst = (dst << 2) | IDXW'(src & IDXW'(3));
                src = src >> 2;
            end
        end else begin
            dst = k;
        end
        return dst;
    endfunction

    // Returns {saturated, formatted value}. The most negative code has no
    // positive magnitude, so it clamps to the largest sign-magnitude negative.
    function automatic logic [WIDTH:0] to_sm(input logic [WIDTH-1:0] v, input logic fmt);
        logic [WIDTH-1:0] mag;
        mag = -v;
        if (!fmt || !v[WIDTH-1]) begin
            return {1'b0, v};
        end
        if (v == {1'b1, {(WIDTH-1){1'b0}}}) begin
            return {1'b1, {WIDTH{1'b1}}};
        end
        return {1'b0, 1'b1, mag[WIDTH-2:0]};
    endfunction

    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = w_out_valid && bus.out_ready;

    // Frame buffer: each slot loads from its lane of the parallel bus on capture.
    for (genvar g = 0; g < N_POINTS; g++) begin : g_slot
        // Per-slot capture register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_re[g] <= '0;
                r_im[g] <= '0;
            end else if (w_in_fire) begin
                r_re[g] <= bus.in_re[g*WIDTH +: WIDTH];
                r_im[g] <= bus.in_im[g*WIDTH +: WIDTH];
            end
        end
    end

    // Output format is latched with the frame so mid-frame changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fmt <= 1'b0;
        end else if (w_in_fire) begin
            r_fmt <= bus.in_fmt;
        end
    end

    // Beat counter: restarts on every capture, wraps to 0 after the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k <= '0;
        end else if (w_in_fire) begin
            r_k <= '0;
        end else if (w_out_fire) begin
            r_k <= (r_k == LAST_K) ? '0 : r_k + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a capture at the last beat keeps streaming with no bubble.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:   if (w_in_fire) w_next_state = STREAM;
            STREAM: if (w_out_fire && w_last && !w_in_fire) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs: handshake flags plus the formatted bin selected by the counter.
    always_comb begin
        w_out_valid   = (r_state == STREAM);
        w_last        = w_out_valid && (r_k == LAST_K);
        w_in_ready    = !reset && ((r_state == IDLE) || (w_out_valid && bus.out_ready && w_last));
        w_slot        = slot_of(r_k);
        w_fmt_re      = to_sm(r_re[w_slot], r_fmt);
        w_fmt_im      = to_sm(r_im[w_slot], r_fmt);
        bus.in_ready  = w_in_ready;
        bus.out_valid = w_out_valid;
        bus.out_last  = w_last;
        bus.out_index = r_k;
        bus.out_re    = w_out_valid ? w_fmt_re[WIDTH-1:0] : '0;
        bus.out_im    = w_out_valid ? w_fmt_im[WIDTH-1:0] : '0;
        bus.out_sat   = w_out_valid && (w_fmt_re[WIDTH] || w_fmt_im[WIDTH]);
    end
endmodule
